// File: rtl/stamp_pkg.sv
// stamp_pkg: shared stamp type, width and saturating delta helper
package stamp_pkg;
    localparam int STAMP_W = 64;
    typedef logic [STAMP_W-1:0] stamp_t;
    // Difference modulo 2^64, clamped to the largest value that fits in w bits
    function automatic stamp_t sat_delta(input stamp_t cur, input stamp_t last, input int unsigned w);
        stamp_t raw;
        stamp_t lim;
        raw = cur - last;
        lim = (w >= STAMP_W) ? '1 : ((stamp_t'(1) << w) - stamp_t'(1));
        return (raw > lim) ? lim : raw;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with registered head output and push-at-full-with-pop support
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic do_push, do_pop;
    assign empty = count_q == '0;
    assign full = count_q == FULL_C;
    assign count = count_q;
    assign head = head_q;
    // Pop only when something is valid; a push at full is accepted only alongside a pop
    always_comb begin
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d = mem_q;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) mem_d[wr_ptr_q] = wdata;
        head_d = (do_push && (empty || (do_pop && count_q == ONE_C))) ? wdata :
                 do_pop ? mem_q[rd_ptr_q + 1'b1] : head_q;
    end
    // Pointer, occupancy and head registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            head_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
            head_q <= head_d;
        end
    end
    // Storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/stamp_delta_buffer.sv
// stamp_delta_buffer: turns new nonzero stamps into saturated inter-event deltas queued for the host
module stamp_delta_buffer
    import stamp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DELTA_W = 32,
    parameter int OVF_W = 8,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [63:0]        stamp_in,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [DELTA_W-1:0] rd_data,
    output logic [CW-1:0]      count,
    output logic [OVF_W-1:0]   ovf_cnt
);
    stamp_t prev_in_q, prev_in_d, last_stamp_q, last_stamp_d;
    logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [DELTA_W-1:0] delta;
    logic evt, pop, full, empty;
    // Event detection, delta computation and drop accounting
    always_comb begin
        evt = !rst && stamp_in != '0 && stamp_in != prev_in_q;
        delta = DELTA_W'(sat_delta(stamp_in, last_stamp_q, DELTA_W));
        pop = rd_ready && !empty;
        prev_in_d = stamp_in;
        last_stamp_d = evt ? stamp_in : last_stamp_q;
        ovf_cnt_d = (evt && full && !pop && ovf_cnt_q != '1) ? ovf_cnt_q + 1'b1 : ovf_cnt_q;
    end
    // Stamp history and overflow counter
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_in_q <= '0;
            last_stamp_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            prev_in_q <= prev_in_d;
            last_stamp_q <= last_stamp_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end
    sync_fifo #(.WIDTH(DELTA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (evt),
        .pop   (pop),
        .wdata (delta),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (rd_data)
    );
    assign rd_valid = !empty;
    assign ovf_cnt = ovf_cnt_q;
endmodule

// File: tb/tb_stamp_delta_buffer.sv
// tb_stamp_delta_buffer: directed scenarios plus randomized traffic against a queue-based model
module tb_stamp_delta_buffer;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rd_ready = 1'b0;
    logic [63:0] stamp_in = '0;
    logic rd_valid;
    logic [31:0] rd_data;
    logic [2:0] count;
    logic [7:0] ovf_cnt;
    int n_tests = 0;
    int n_fail = 0;
    logic [63:0] m_prev = '0;
    logic [63:0] m_last = '0;
    logic [31:0] mq[$];
    int m_ovf = 0;

    always #5 clk = ~clk;

    stamp_delta_buffer #(.DEPTH(DEPTH), .DELTA_W(32), .OVF_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .stamp_in (stamp_in),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .ovf_cnt  (ovf_cnt)
    );

    function automatic logic [31:0] ref_delta(input logic [63:0] s, input logic [63:0] l);
        logic [63:0] r;
        r = s - l;
        return (r >= 64'h1_0000_0000) ? 32'hFFFF_FFFF : r[31:0];
    endfunction

    task automatic step(input logic [63:0] s, input logic r);
        bit was_full, pop, ev;
        logic [31:0] d;
        stamp_in = s;
        rd_ready = r;
        @(posedge clk);
        was_full = mq.size() == DEPTH;
        pop = mq.size() > 0 && r;
        ev = s != 0 && s != m_prev;
        d = ref_delta(s, m_last);
        if (ev) m_last = s;
        if (pop) void'(mq.pop_front());
        if (ev) begin
            if (!was_full || pop) mq.push_back(d);
            else if (m_ovf < 255) m_ovf++;
        end
        m_prev = s;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [63:0] s);
        rst = 1'b1;
        stamp_in = s;
        rd_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        m_prev = '0;
        m_last = '0;
        mq.delete();
        m_ovf = 0;
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset(64'd0);
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rd_valid); end
        n_tests++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %0h want 0", rd_data); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_tests++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_ovf got %0d want 0", ovf_cnt); end
    endtask

    task automatic test_basic();
        do_reset(64'd0);
        step(64'd0, 1'b0);
        step(64'd0, 1'b0);
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_zero_valid got %b want 0", rd_valid); end
        step(64'd5, 1'b0);
        n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_first_valid got %b want 1", rd_valid); end
        n_tests++; if (rd_data !== 32'd5) begin n_fail++; $display("FAIL basic_first_data got %0d want 5", rd_data); end
        step(64'd5, 1'b0);
        step(64'd5, 1'b0);
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL basic_hold_count got %0d want 1", count); end
        step(64'd9, 1'b0);
        n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL basic_count got %0d want 2", count); end
        n_tests++; if (rd_data !== 32'd5) begin n_fail++; $display("FAIL basic_stable got %0d want 5", rd_data); end
        step(64'd9, 1'b1);
        n_tests++; if (rd_data !== 32'd4) begin n_fail++; $display("FAIL basic_second_data got %0d want 4", rd_data); end
        step(64'd9, 1'b1);
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got %b want 0", rd_valid); end
        step(64'd9, 1'b1);
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL basic_empty_pop got %0d want 0", count); end
    endtask

    task automatic test_saturate();
        do_reset(64'd0);
        step(64'd10, 1'b0);
        step(64'h100_0000_000A, 1'b0);
        step(64'h100_0000_000A, 1'b1);
        n_tests++; if (rd_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_data got %0h want ffffffff", rd_data); end
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL sat_count got %0d want 1", count); end
    endtask

    task automatic test_overflow();
        logic [63:0] st [6] = '{64'd3, 64'd8, 64'd20, 64'd21, 64'd50, 64'd51};
        logic [31:0] ex [4] = '{32'd3, 32'd5, 32'd12, 32'd1};
        do_reset(64'd0);
        for (int i = 0; i < 6; i++) step(st[i], 1'b0);
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d want 4", count); end
        n_tests++; if (ovf_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_cnt got %0d want 2", ovf_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (rd_data !== ex[i]) begin n_fail++; $display("FAIL ovf_drain%0d got %0d want %0d", i, rd_data, ex[i]); end
            step(64'd51, 1'b1);
        end
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got %b want 0", rd_valid); end
    endtask

    task automatic test_full_pushpop();
        logic [63:0] st [4] = '{64'd1, 64'd3, 64'd6, 64'd10};
        logic [31:0] ex [4] = '{32'd2, 32'd3, 32'd4, 32'd10};
        do_reset(64'd0);
        for (int i = 0; i < 4; i++) step(st[i], 1'b0);
        step(64'd20, 1'b1);
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL fullpp_count got %0d want 4", count); end
        n_tests++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL fullpp_ovf got %0d want 0", ovf_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (rd_data !== ex[i]) begin n_fail++; $display("FAIL fullpp_drain%0d got %0d want %0d", i, rd_data, ex[i]); end
            step(64'd20, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] st [6] = '{64'd3, 64'd8, 64'd20, 64'd21, 64'd50, 64'd51};
        do_reset(64'd0);
        for (int i = 0; i < 6; i++) step(st[i], 1'b0);
        step(64'd51, 1'b1);
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count got %0d want 3", count); end
        do_reset(64'd99);
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", rd_valid); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", count); end
        n_tests++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_ovf got %0d want 0", ovf_cnt); end
        step(64'd7, 1'b0);
        n_tests++; if (rd_data !== 32'd7) begin n_fail++; $display("FAIL mid_data got %0d want 7", rd_data); end
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL mid_post_count got %0d want 1", count); end
    endtask

    task automatic test_ovf_sat();
        do_reset(64'd0);
        for (int i = 1; i <= 260; i++) step(64'(i), 1'b0);
        n_tests++; if (ovf_cnt !== 8'd255) begin n_fail++; $display("FAIL ovfsat_hold got %0d want 255", ovf_cnt); end
        step(64'd1000, 1'b0);
        n_tests++; if (ovf_cnt !== 8'd255) begin n_fail++; $display("FAIL ovfsat_again got %0d want 255", ovf_cnt); end
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL ovfsat_count got %0d want 4", count); end
    endtask

    task automatic test_random();
        logic [63:0] s;
        int pr;
        do_reset(64'd0);
        for (int c = 0; c < 3000; c++) begin
            pr = (c / 200) % 3;
            case ($urandom_range(0, 7))
                0: s = '0;
                1, 2: s = m_prev;
                3, 4, 5: s = m_prev + 64'($urandom_range(1, 100));
                6: s = {$urandom, $urandom};
                default: s = m_prev + {24'd0, 8'($urandom_range(0, 255)), $urandom};
            endcase
            step(s, pr == 0 ? 1'b1 : pr == 1 ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0));
            n_tests++; if (rd_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c=%0d got %b want %b", c, rd_valid, mq.size() != 0); end
            n_tests++; if (count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_count c=%0d got %0d want %0d", c, count, mq.size()); end
            n_tests++; if (ovf_cnt !== 8'(m_ovf)) begin n_fail++; $display("FAIL rnd_ovf c=%0d got %0d want %0d", c, ovf_cnt, m_ovf); end
            if (mq.size() != 0) begin
                n_tests++; if (rd_data !== mq[0]) begin n_fail++; $display("FAIL rnd_data c=%0d got %0h want %0h", c, rd_data, mq[0]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_overflow();
        test_full_pushpop();
        test_reset_mid();
        test_ovf_sat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stamp_delta_buffer.md
# stamp_delta_buffer

Consumes the 64-bit `out` stream of the input/compute state machine and records the wall-clock stamps it emits. Each new nonzero stamp becomes an inter-event delta, the cycles since the previous stamp. Deltas are queued in a small FIFO that the host drains over a valid/ready handshake. Push timing depends only on event detection, never on stamp or delta values, so the block adds no data-dependent latency to the path.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `DELTA_W`, 32: delta width in bits; at most 64.
- `OVF_W`, 8: width of the overflow counter.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stamp_in`  in  64  upstream `out`, sampled every cycle.
- `rd_ready`  in  1  host accepts `rd_data` this cycle.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_data`  out  DELTA_W  head-of-FIFO delta.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `ovf_cnt`  out  OVF_W  dropped-event count, saturating.

## Operation
- Reset values: `rd_valid`=0, `rd_data`=0, `count`=0, `ovf_cnt`=0.
- Internal registers `prev_in` and `last_stamp` both reset to 0.
- `prev_in` <= `stamp_in` every cycle.
- Event: `stamp_in != 0` and `stamp_in != prev_in`.
  - Zero means "compute started", not an event.
  - A held value (upstream busy in compute states) is not an event.
- On an event:
  - raw = `stamp_in - last_stamp`, modulo 2^64.
  - delta = raw, saturated to 2^DELTA_W-1 if raw ≥ 2^DELTA_W.
  - `last_stamp` <= `stamp_in`. This update happens even when the push is dropped.
- First event after reset uses `last_stamp`=0, so delta = stamp, saturated.
- Push: on an event, if the FIFO is not full, or a pop occurs the same cycle.
- Pop: on `rd_valid && rd_ready`.
- Full with no pop: the event's delta is dropped and `ovf_cnt` increments. It saturates at 2^OVF_W-1.
- Empty and `rd_ready` high: no pop, no side effect.
- Pointers wrap modulo DEPTH. `count` distinguishes full from empty.
- Push and pop in the same cycle:
  - `count` unchanged.
  - Legal at full and at any occupancy in between.
  - At empty only the push happens, since nothing is valid to pop.
- Reset in mid-operation clears the FIFO, pointers, `count`, `ovf_cnt`, `prev_in` and `last_stamp` on the next edge.
  - Queued deltas are discarded.
  - The event test is suppressed in the reset cycle.

## Timing
- Event at edge t is sampled at edge t. `rd_valid` rises after edge t, visible in cycle t+1 if the FIFO was empty. There is no combinational bypass.
- `rd_data` is registered head data. It is stable while `rd_valid && !rd_ready`.
- After a pop at edge t, the next entry appears at cycle t+1.
- Throughput: one push and one pop per cycle.
- No path from `stamp_in` to any output within the same cycle.
- No path from `rd_ready` to any output within the same cycle.
- Latency is fixed at 1 cycle, independent of delta value and of saturation.

## Structure
- Shared package `stamp_pkg` holds:
  - `STAMP_W`=64;
  - the `stamp_t` typedef;
  - the saturating-subtract function `sat_delta`.
- Sub-module `sync_fifo` is parameterised by width and depth. It exposes:
  - push/pop/full/empty/count;
  - registered head output;
  - defined behaviour for simultaneous push and pop at full.
- The top level contains event detection, `last_stamp`, delta saturation and the overflow counter.

## Test plan
- Reset, then `stamp_in` = 0, 0, 5, 5, 5, 9 -> deltas 5 then 4. `rd_valid` first high the cycle after 5 is sampled. `count` reaches 2.
- Event with `last_stamp`=10 and `stamp_in`=2^40+10, DELTA_W=32 -> `rd_data`=0xFFFFFFFF.
- `rd_ready`=0 and 6 distinct events, DEPTH=4 -> `count`=4, `ovf_cnt`=2. Draining yields the first 4 deltas in order.
- FIFO full, event and `rd_ready`=1 in the same cycle -> `count` stays 4, `ovf_cnt` unchanged. The new delta lands at the tail.
- `rst` asserted for one cycle with 3 entries queued -> next cycle `rd_valid`=0, `count`=0, `ovf_cnt`=0. The following stamp 7 gives delta 7.
- Hold `ovf_cnt` at 255, then overflow again -> `ovf_cnt` stays 255.
